// File: rtl/test_seq_pkg.sv
// Shared types for the test sequencer: state encoding, phase codes,
// mode_en bit positions and the phase-ordering helper.
package test_seq_pkg;

    localparam int TMR_W = 16;

    localparam int M_TRIM = 0;
    localparam int M_RX   = 1;
    localparam int M_TX   = 2;
    localparam int M_ADV  = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_TRIM     = 4'd1,
        ST_RX       = 4'd2,
        ST_ENDWAIT  = 4'd3,
        ST_GAP      = 4'd4,
        ST_TX       = 4'd5,
        ST_ADV      = 4'd6,
        ST_NEXT_BUS = 4'd7,
        ST_DONE     = 4'd8
    } st_t;

    // First enabled test phase strictly after cur; IDLE/NEXT_BUS mean "start of a bus".
    // RX is never passed as cur because it always continues into ENDWAIT.
    function automatic st_t next_phase(st_t cur, logic [3:0] m);
        st_t r;
        r = ST_NEXT_BUS;
        if (m[M_ADV] && cur != ST_ADV) r = ST_ADV;
        if (m[M_TX] && (cur inside {ST_IDLE, ST_NEXT_BUS, ST_TRIM, ST_GAP})) r = ST_TX;
        if (m[M_RX] && (cur inside {ST_IDLE, ST_NEXT_BUS, ST_TRIM})) r = ST_RX;
        if (m[M_TRIM] && (cur inside {ST_IDLE, ST_NEXT_BUS})) r = ST_TRIM;
        return r;
    endfunction

    // NEXT_BUS and DONE share the wrap-up code 7; done tells them apart.
    function automatic logic [2:0] phase_code(st_t s);
        if (s == ST_DONE) return 3'd7;
        return 3'(s);
    endfunction

endpackage

// File: rtl/test_sequencer_seq_timer.sv
// Loadable down-counter; tc marks the last cycle of a loaded interval,
// so a load of N spans exactly N cycles in the following state.
module seq_timer
    import test_seq_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk_40_m,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign tc = (cnt == ONE);

endmodule

// File: rtl/test_sequencer.sv
// Per-bus test sequencer: trim, rx (+endwait, gap), tx and advanced phases
// across N_BUSES buses with per-phase timeout and pass/error status.
//
// state    | meaning
// IDLE     | waiting for sign_on
// TRIM     | oscillator auto-trim, wait trim_done
// RX       | receive test, wait rx_end
// ENDWAIT  | endwait_all pulse
// GAP      | idle gap between RX and TX
// TX       | transmit test, wait tx_end
// ADV      | advanced test, wait msg_end
// NEXT_BUS | tally bus result, advance bus_sel
// DONE     | one-cycle done pulse
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_BUSES        = 2,
    parameter int GAP_CYCLES     = 120,
    parameter int ENDWAIT_CYCLES = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_40_m,
    input  logic       rst,
    input  logic       sign_on,
    input  logic       abort,
    input  logic [3:0] mode_en,
    input  logic       trim_done,
    input  logic       rx_end,
    input  logic       tx_end,
    input  logic       msg_end,
    output logic       osc_auto_trim,
    output logic       test_rx,
    output logic       test_tx,
    output logic       test_advanced,
    output logic       endwait_all,
    output logic [4:0] bus_sel,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [4:0] err_bus,
    output logic [5:0] pass_cnt
);

    localparam logic [4:0] LAST_BUS = 5'(N_BUSES - 1);

    st_t              state, state_nx;
    logic [3:0]       mode_q;
    logic             bus_err;
    logic             strobe, start, to_hit, bus_step;
    logic             tmr_load, tmr_tc;
    logic [TMR_W-1:0] tmr_val;

    always_comb begin
        state_nx = state;
        strobe   = 1'b0;
        start    = 1'b0;
        to_hit   = 1'b0;
        bus_step = 1'b0;
        case (state)
            ST_TRIM: strobe = trim_done;
            ST_RX:   strobe = rx_end;
            ST_TX:   strobe = tx_end;
            ST_ADV:  strobe = msg_end;
            default: strobe = 1'b0;
        endcase

        case (state)
            ST_IDLE: begin
                if (sign_on) begin
                    start    = 1'b1;
                    state_nx = (mode_en == 4'd0) ? ST_DONE : next_phase(ST_IDLE, mode_en);
                end
            end
            ST_TRIM, ST_RX, ST_TX, ST_ADV: begin
                // a strobe landing on the expiry cycle still counts as success
                if (strobe) begin
                    state_nx = (state == ST_RX) ? ST_ENDWAIT : next_phase(state, mode_q);
                end else if (tmr_tc) begin
                    state_nx = ST_NEXT_BUS;
                    to_hit   = 1'b1;
                end
            end
            ST_ENDWAIT: if (tmr_tc) state_nx = ST_GAP;
            ST_GAP:     if (tmr_tc) state_nx = next_phase(ST_GAP, mode_q);
            ST_NEXT_BUS: begin
                bus_step = 1'b1;
                state_nx = (bus_sel == LAST_BUS) ? ST_DONE : next_phase(ST_NEXT_BUS, mode_q);
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        if (abort && state != ST_IDLE) begin
            state_nx = ST_IDLE;
            to_hit   = 1'b0;
            bus_step = 1'b0;
        end

        tmr_load = (state_nx != state);
        case (state_nx)
            ST_ENDWAIT: tmr_val = TMR_W'(ENDWAIT_CYCLES);
            ST_GAP:     tmr_val = TMR_W'(GAP_CYCLES);
            default:    tmr_val = TMR_W'(TIMEOUT_CYCLES);
        endcase
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state         <= ST_IDLE;
            mode_q        <= 4'd0;
            bus_err       <= 1'b0;
            osc_auto_trim <= 1'b0;
            test_rx       <= 1'b0;
            test_tx       <= 1'b0;
            test_advanced <= 1'b0;
            endwait_all   <= 1'b0;
            phase         <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus_sel       <= 5'd0;
            timeout_err   <= 1'b0;
            err_bus       <= 5'd0;
            pass_cnt      <= 6'd0;
        end else begin
            state         <= state_nx;
            osc_auto_trim <= (state_nx == ST_TRIM);
            test_rx       <= (state_nx == ST_RX);
            test_tx       <= (state_nx == ST_TX);
            test_advanced <= (state_nx == ST_ADV);
            endwait_all   <= (state_nx == ST_ENDWAIT);
            phase         <= phase_code(state_nx);
            busy          <= (state_nx != ST_IDLE);
            done          <= (state_nx == ST_DONE);

            if (start) begin
                mode_q      <= mode_en;
                bus_sel     <= 5'd0;
                timeout_err <= 1'b0;
                err_bus     <= 5'd0;
                bus_err     <= 1'b0;
                pass_cnt    <= (mode_en == 4'd0) ? 6'(N_BUSES) : 6'd0;
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
                bus_err     <= 1'b1;
                if (!timeout_err) err_bus <= bus_sel;
            end
            if (bus_step) begin
                bus_err <= 1'b0;
                if (!bus_err) pass_cnt <= pass_cnt + 6'd1;
                if (bus_sel != LAST_BUS) bus_sel <= bus_sel + 5'd1;
            end
        end
    end

    seq_timer #(.W(TMR_W)) u_timer (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: table rows, randomized runs against
// a segment-list reference model, plus reset/abort corner sequences.
module tb_test_sequencer;

    localparam int N  = 2;
    localparam int G  = 120;
    localparam int EW = 1;
    localparam int T  = 20;

    logic       clk_40_m = 1'b0;
    logic       rst = 1'b0;
    logic       sign_on = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] mode_en = 4'd0;
    logic       trim_done = 1'b0, rx_end = 1'b0, tx_end = 1'b0, msg_end = 1'b0;
    logic       osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all;
    logic [4:0] bus_sel, err_bus;
    logic [2:0] phase;
    logic       busy, done, timeout_err;
    logic [5:0] pass_cnt;

    always #5 clk_40_m = ~clk_40_m;

    test_sequencer #(
        .N_BUSES(N), .GAP_CYCLES(G), .ENDWAIT_CYCLES(EW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_40_m(clk_40_m), .rst(rst), .sign_on(sign_on), .abort(abort),
        .mode_en(mode_en), .trim_done(trim_done), .rx_end(rx_end),
        .tx_end(tx_end), .msg_end(msg_end), .osc_auto_trim(osc_auto_trim),
        .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced),
        .endwait_all(endwait_all), .bus_sel(bus_sel), .phase(phase),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .err_bus(err_bus), .pass_cnt(pass_cnt)
    );

    int total = 0;
    int bad   = 0;

    // strobe delay per [bus][trim,rx,tx,adv]: phase lasts d cycles; 0 = never answer
    int dly[2][4];
    bit noise_on = 1'b0;

    typedef struct { int lbl; int bus; } seg_t;

    typedef struct {
        logic [3:0] m;
        int d0;
        int d1;
        int pass;
        bit err;
        int ebus;
    } row_t;
    row_t rows[9];

    logic [14:0] dut_vec;
    assign dut_vec = {phase, osc_auto_trim, test_rx, test_tx, test_advanced,
                      endwait_all, busy, done, bus_sel};

    // label: 1 trim, 2 rx, 3 endwait, 4 gap, 5 tx, 6 adv, 7 next bus, 8 done
    function automatic logic [14:0] exp_vec(int lbl, int bus);
        logic [2:0] ph;
        ph = (lbl == 8) ? 3'd7 : 3'(lbl);
        return {ph, lbl == 1, lbl == 2, lbl == 5, lbl == 6, lbl == 3, 1'b1, lbl == 8, 5'(bus)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // responder: answers the active phase after its programmed delay, optional noise on idle strobes
    int kt = 0, kr = 0, kx = 0, ka = 0;
    always @(negedge clk_40_m) begin
        int b;
        b  = (bus_sel < 5'(N)) ? int'(bus_sel) : 0;
        kt = osc_auto_trim ? kt + 1 : 0;
        kr = test_rx       ? kr + 1 : 0;
        kx = test_tx       ? kx + 1 : 0;
        ka = test_advanced ? ka + 1 : 0;
        trim_done = osc_auto_trim ? (kt == dly[b][0]) : (noise_on && $urandom_range(3) == 0);
        rx_end    = test_rx       ? (kr == dly[b][1]) : (noise_on && $urandom_range(3) == 0);
        tx_end    = test_tx       ? (kx == dly[b][2]) : (noise_on && $urandom_range(3) == 0);
        msg_end   = test_advanced ? (ka == dly[b][3]) : (noise_on && $urandom_range(3) == 0);
    end

    // builds the expected cycle-by-cycle segment list from the phase rules, then runs and compares it
    task automatic run_seq(input logic [3:0] m, output int pass, output bit err, output int ebus);
        seg_t q[$];
        int   lbl[4];
        bit   berr, ok, diverged;
        int   d, len, cyc;
        logic [14:0] e;
        lbl  = '{1, 2, 5, 6};
        pass = 0;
        err  = 1'b0;
        ebus = 0;
        if (m == 4'd0) begin
            q.push_back('{8, 0});
            pass = N;
        end else begin
            for (int b = 0; b < N; b++) begin
                berr = 1'b0;
                for (int p = 0; p < 4; p++) begin
                    if (m[p] && !berr) begin
                        d   = dly[b][p];
                        ok  = (d >= 1 && d <= T);
                        len = ok ? d : T;
                        repeat (len) q.push_back('{lbl[p], b});
                        if (!ok) begin
                            if (!err) ebus = b;
                            err  = 1'b1;
                            berr = 1'b1;
                        end else if (p == 1) begin
                            repeat (EW) q.push_back('{3, b});
                            repeat (G) q.push_back('{4, b});
                        end
                    end
                end
                q.push_back('{7, b});
                if (!berr) pass++;
            end
            q.push_back('{8, N - 1});
        end

        @(negedge clk_40_m);
        sign_on = 1'b1;
        mode_en = m;
        @(negedge clk_40_m);
        sign_on  = 1'b0;
        diverged = 1'b0;
        foreach (q[i]) begin
            if (!diverged) begin
                e = exp_vec(q[i].lbl, q[i].bus);
                total++;
                if (dut_vec !== e) begin
                    bad++;
                    diverged = 1'b1;
                    $display("FAIL trace mode=%b cyc=%0d actual=%h required=%h", m, i, dut_vec, e);
                end
            end
            if (noise_on) begin
                sign_on = 1'($urandom_range(1));
                mode_en = 4'($urandom);
            end
            @(negedge clk_40_m);
        end
        sign_on = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clk_40_m);
            cyc++;
        end
        check("idle_after_run", {busy, done, phase}, 5'd0);
    endtask

    task automatic set_dly(input int d0, input int d1);
        for (int p = 0; p < 4; p++) begin
            dly[0][p] = d0;
            dly[1][p] = d1;
        end
    endtask

    initial begin
        int   mp, me;
        bit   merr;
        int   cyc, dcnt;

        rows[0] = '{4'b0010, 10, 10, 2, 1'b0, 0};
        rows[1] = '{4'b1111,  5,  5, 2, 1'b0, 0};
        rows[2] = '{4'b0100,  5,  0, 1, 1'b1, 1};
        rows[3] = '{4'b0010, 20, 20, 2, 1'b0, 0};
        rows[4] = '{4'b0000,  3,  3, 2, 1'b0, 0};
        rows[5] = '{4'b0001,  0,  0, 0, 1'b1, 0};
        rows[6] = '{4'b0010, 21,  7, 1, 1'b1, 0};
        rows[7] = '{4'b1010, 12,  3, 2, 1'b0, 0};
        rows[8] = '{4'b1000,  5, 25, 1, 1'b1, 1};
        set_dly(0, 0);

        repeat (3) @(negedge clk_40_m);
        check("reset_outputs", {dut_vec, pass_cnt, timeout_err, err_bus}, 0);
        rst = 1'b1;
        @(negedge clk_40_m);
        check("idle_after_reset", {busy, phase, bus_sel}, 0);

        foreach (rows[i]) begin
            set_dly(rows[i].d0, rows[i].d1);
            run_seq(rows[i].m, mp, merr, me);
            check($sformatf("row%0d_pass", i), pass_cnt, rows[i].pass);
            check($sformatf("row%0d_err", i), timeout_err, rows[i].err);
            check($sformatf("row%0d_err_bus", i), err_bus, rows[i].ebus);
        end

        // reset in the middle of TX: everything, including held status, clears
        set_dly(0, 0);
        @(negedge clk_40_m);
        sign_on = 1'b1;
        mode_en = 4'b0100;
        @(negedge clk_40_m);
        sign_on = 1'b0;
        cyc = 0;
        while (!test_tx && cyc < 10) begin
            @(negedge clk_40_m);
            cyc++;
        end
        check("tx_seen", test_tx, 1'b1);
        repeat (3) @(negedge clk_40_m);
        rst = 1'b0;
        @(negedge clk_40_m);
        check("rst_mid_tx", {dut_vec, pass_cnt, timeout_err, err_bus}, 0);
        rst = 1'b1;
        @(negedge clk_40_m);

        // abort in RX on bus 1: IDLE next cycle, no done, status held
        dly[0][1] = 5;
        dly[1][1] = 0;
        sign_on = 1'b1;
        mode_en = 4'b0010;
        @(negedge clk_40_m);
        sign_on = 1'b0;
        cyc = 0;
        while (!(test_rx && bus_sel == 5'd1) && cyc < 300) begin
            @(negedge clk_40_m);
            cyc++;
        end
        check("rx_bus1_seen", {test_rx, bus_sel}, 6'h21);
        repeat (4) @(negedge clk_40_m);
        abort = 1'b1;
        @(negedge clk_40_m);
        abort = 1'b0;
        check("abort_outs", {test_rx, busy, done, phase}, 0);
        check("abort_status", {pass_cnt, bus_sel, timeout_err}, {6'd1, 5'd1, 1'b0});
        dcnt = 0;
        repeat (6) begin
            @(negedge clk_40_m);
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);

        noise_on = 1'b1;
        for (int r = 0; r < 12; r++) begin
            for (int b = 0; b < N; b++)
                for (int p = 0; p < 4; p++)
                    dly[b][p] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(25, 1));
            run_seq(4'($urandom), mp, merr, me);
            check($sformatf("rand%0d_pass", r), pass_cnt, mp);
            check($sformatf("rand%0d_err", r), timeout_err, merr);
            check($sformatf("rand%0d_err_bus", r), err_bus, me);
        end
        noise_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
